// File: rtl/h80cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// h80cpu_bus_arbiter
//
// Lets two masters share one toggle-handshake memory slave (h80cpu_mem).
// Master 0 is the CPU fetch/data port. Master 1 is a secondary requester
// (DMA / debug loader). On every port a request is pending while run != done,
// and the responder completes it by toggling done.
//
// The arbiter accepts one request at a time. It registers that master's
// address, command and write data, then forwards the request to the slave.
// When the slave completes, the arbiter returns the slave's read data and the
// completion toggle to the master that was granted.
//
// Optional feature (macro H80CPU_ARB_ROUND_ROBIN_EN):
//   undefined : fixed priority; master 0 wins whenever it is pending, so
//               master 1 can starve under continuous master 0 traffic
//   defined   : round robin; on a tie the master that was not granted last
//               wins (last_grant resets to 1, so master 0 wins the first tie)
//
// Ports:
//   clk, reset                  bus clock, asynchronous active-high reset
//   m0_addr/cmd/run/wr_data     master 0 request (sampled only at grant)
//   m0_rd_data, m0_done         master 0 registered read data / done toggle
//   m1_*                        same as m0_*, for master 1
//   s_addr/cmd/run/wr_data      registered request to the slave
//   s_rd_data, s_done           slave read data / completion toggle
//   grant                       owning master index, valid while busy
//   busy                        a slave transaction is outstanding
//
// state | meaning
// IDLE  | no slave transaction outstanding; the next winner is picked here
// WAIT  | request forwarded; waiting until s_done catches up with s_run
// -----------------------------------------------------------------------------
module h80cpu_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CMD_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [CMD_W-1:0]  m0_cmd,
    input  logic              m0_run,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_done,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [CMD_W-1:0]  m1_cmd,
    input  logic              m1_run,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_done,
    output logic [ADDR_W-1:0] s_addr,
    output logic [CMD_W-1:0]  s_cmd,
    output logic              s_run,
    output logic [DATA_W-1:0] s_wr_data,
    input  logic [DATA_W-1:0] s_rd_data,
    input  logic              s_done,
    output logic              grant,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic              pend0, pend1, win;
    logic [ADDR_W-1:0] s_addr_nxt;
    logic [CMD_W-1:0]  s_cmd_nxt;
    logic [DATA_W-1:0] s_wr_data_nxt;
    logic              s_run_nxt, grant_nxt, busy_nxt;
    logic [DATA_W-1:0] m0_rd_data_nxt, m1_rd_data_nxt;
    logic              m0_done_nxt, m1_done_nxt;

    // Pending is computed from the registered done toggles.
    assign pend0 = m0_run ^ m0_done;
    assign pend1 = m1_run ^ m1_done;

`ifdef H80CPU_ARB_ROUND_ROBIN_EN
    logic last_grant, last_grant_nxt;

    // On a tie the master not granted last wins; a sole requester always wins.
    assign win = (pend0 && pend1) ? ~last_grant : pend1;
`else
    assign win = ~pend0;
`endif

    always_comb begin
        state_nxt      = state;
        s_addr_nxt     = s_addr;
        s_cmd_nxt      = s_cmd;
        s_wr_data_nxt  = s_wr_data;
        s_run_nxt      = s_run;
        grant_nxt      = grant;
        busy_nxt       = busy;
        m0_rd_data_nxt = m0_rd_data;
        m1_rd_data_nxt = m1_rd_data;
        m0_done_nxt    = m0_done;
        m1_done_nxt    = m1_done;
`ifdef H80CPU_ARB_ROUND_ROBIN_EN
        last_grant_nxt = last_grant;
`endif
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    s_addr_nxt    = win ? m1_addr    : m0_addr;
                    s_cmd_nxt     = win ? m1_cmd     : m0_cmd;
                    s_wr_data_nxt = win ? m1_wr_data : m0_wr_data;
                    s_run_nxt     = ~s_run;
                    grant_nxt     = win;
                    busy_nxt      = 1'b1;
                    state_nxt     = WAIT;
`ifdef H80CPU_ARB_ROUND_ROBIN_EN
                    last_grant_nxt = win;
`endif
                end
            end
            WAIT: begin
                if (s_run == s_done) begin
                    if (grant) begin
                        m1_rd_data_nxt = s_rd_data;
                        m1_done_nxt    = ~m1_done;
                    end else begin
                        m0_rd_data_nxt = s_rd_data;
                        m0_done_nxt    = ~m0_done;
                    end
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            s_addr     <= '0;
            s_cmd      <= '0;
            s_wr_data  <= '0;
            s_run      <= 1'b0;
            grant      <= 1'b0;
            busy       <= 1'b0;
            m0_rd_data <= '0;
            m1_rd_data <= '0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
`ifdef H80CPU_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            s_addr     <= s_addr_nxt;
            s_cmd      <= s_cmd_nxt;
            s_wr_data  <= s_wr_data_nxt;
            s_run      <= s_run_nxt;
            grant      <= grant_nxt;
            busy       <= busy_nxt;
            m0_rd_data <= m0_rd_data_nxt;
            m1_rd_data <= m1_rd_data_nxt;
            m0_done    <= m0_done_nxt;
            m1_done    <= m1_done_nxt;
`ifdef H80CPU_ARB_ROUND_ROBIN_EN
            last_grant <= last_grant_nxt;
`endif
        end
    end

    // A granted master must not re-toggle run before its done comes back.
    a_master_retoggle: assert property (@(posedge clk) disable iff (reset)
        (state == WAIT) |-> (grant ? pend1 : pend0));

    // The slave must not toggle done when nothing is outstanding.
    a_slave_spurious_done: assert property (@(posedge clk) disable iff (reset)
        (state == IDLE) |-> (s_run == s_done));

endmodule

// File: tb/tb_h80cpu_bus_arbiter.sv
module tb_h80cpu_bus_arbiter;

    localparam logic [2:0] CMD_RD_W = 3'd0;
    localparam logic [2:0] CMD_WR_W = 3'd1;
`ifdef H80CPU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [2:0]  m0_cmd = '0, m1_cmd = '0;
    logic        m0_run = 1'b0, m1_run = 1'b0;
    logic [15:0] m0_wr_data = '0, m1_wr_data = '0;
    logic [15:0] m0_rd_data, m1_rd_data;
    logic        m0_done, m1_done;
    logic [15:0] s_addr, s_wr_data;
    logic [2:0]  s_cmd;
    logic        s_run;
    logic [15:0] s_rd_data = '0;
    logic        s_done = 1'b0;
    logic        grant, busy;

    h80cpu_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .CMD_W(3)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_run(m0_run), .m0_wr_data(m0_wr_data),
        .m0_rd_data(m0_rd_data), .m0_done(m0_done),
        .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_run(m1_run), .m1_wr_data(m1_wr_data),
        .m1_rd_data(m1_rd_data), .m1_done(m1_done),
        .s_addr(s_addr), .s_cmd(s_cmd), .s_run(s_run), .s_wr_data(s_wr_data),
        .s_rd_data(s_rd_data), .s_done(s_done),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          m;
        logic [2:0]  cmd;
        logic [15:0] addr;
        logic [15:0] data;
    } iss_t;

    iss_t        iq[$];
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    bit          tb_last = 1'b1;
    int          issue_cnt = 0, done_cnt0 = 0, done_cnt1 = 0;

    // Slave model: responds slave_delay cycles after it notices a request.
    logic [15:0] smem [logic [15:0]];
    int          slave_delay = 1;
    bit          sl_busy = 1'b0;
    int          sl_cnt = 0;

    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            s_done  = 1'b0;
            sl_busy = 1'b0;
        end else if (sl_busy) begin
            sl_cnt--;
            if (sl_cnt <= 0) begin
                if (s_cmd[0]) begin
                    smem[s_addr] = s_wr_data;
                    s_rd_data    = s_wr_data;
                end else begin
                    s_rd_data = smem.exists(s_addr) ? smem[s_addr] : (s_addr ^ 16'h5A5A);
                end
                s_done  = ~s_done;
                sl_busy = 1'b0;
            end
        end else if (s_run != s_done) begin
            sl_busy = 1'b1;
            sl_cnt  = slave_delay;
        end
    end

    // Issue and completion monitors: pop the scoreboard when the DUT acts.
    logic prev_s_run = 1'b0, prev_d0 = 1'b0, prev_d1 = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (s_run !== prev_s_run) begin
                iss_t e;
                issue_cnt++;
                checks++;
                if (iq.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected got grant=%0d addr=%h want no issue", grant, s_addr);
                end else begin
                    e = iq.pop_front();
                    if (grant !== e.m || s_addr !== e.addr || s_cmd !== e.cmd ||
                        s_wr_data !== e.data || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL issue got grant=%0d addr=%h cmd=%0d wd=%h busy=%0d want grant=%0d addr=%h cmd=%0d wd=%h busy=1",
                                 grant, s_addr, s_cmd, s_wr_data, busy, e.m, e.addr, e.cmd, e.data);
                    end
                end
            end
            if (m0_done !== prev_d0) begin
                done_cnt0++;
                checks++;
                if (mq0.size() == 0) begin
                    errors++;
                    $display("FAIL m0_done_unexpected got toggle want none");
                end else begin
                    logic [15:0] x;
                    x = mq0.pop_front();
                    if (m0_rd_data !== x || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL m0_complete got rd=%h busy=%0d want rd=%h busy=0", m0_rd_data, busy, x);
                    end
                end
            end
            if (m1_done !== prev_d1) begin
                done_cnt1++;
                checks++;
                if (mq1.size() == 0) begin
                    errors++;
                    $display("FAIL m1_done_unexpected got toggle want none");
                end else begin
                    logic [15:0] x;
                    x = mq1.pop_front();
                    if (m1_rd_data !== x || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL m1_complete got rd=%h busy=%0d want rd=%h busy=0", m1_rd_data, busy, x);
                    end
                end
            end
        end
        prev_s_run = s_run;
        prev_d0    = m0_done;
        prev_d1    = m1_done;
    end

    function automatic bit tie_winner();
        if (RR) return ~tb_last;
        return 1'b0;
    endfunction

    task automatic expect_issue(input bit m, input logic [2:0] cmd, input logic [15:0] addr,
                                input logic [15:0] data);
        iss_t e;
        e.m = m; e.cmd = cmd; e.addr = addr; e.data = data;
        iq.push_back(e);
        tb_last = m;
    endtask

    task automatic raise(input bit m, input logic [2:0] cmd, input logic [15:0] addr,
                         input logic [15:0] data, input logic [15:0] exp_rd);
        if (m == 1'b0) begin
            m0_addr = addr; m0_cmd = cmd; m0_wr_data = data; m0_run = ~m0_run;
            mq0.push_back(exp_rd);
        end else begin
            m1_addr = addr; m1_cmd = cmd; m1_wr_data = data; m1_run = ~m1_run;
            mq1.push_back(exp_rd);
        end
    endtask

    task automatic wait_quiet(input int budget);
        int t = 0;
        while (1) begin
            @(negedge clk);
            if (iq.size() == 0 && mq0.size() == 0 && mq1.size() == 0 && busy === 1'b0 &&
                m0_run === m0_done && m1_run === m1_done) break;
            t++;
            if (t > budget) begin
                checks++;
                errors++;
                $display("FAIL quiet_timeout got iq=%0d mq0=%0d mq1=%0d busy=%0d want all drained within %0d cycles",
                         iq.size(), mq0.size(), mq1.size(), busy, budget);
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [15:0] vals[10];
        string       names[10];
        vals  = '{m0_rd_data, m1_rd_data, 16'(m0_done), 16'(m1_done), s_addr,
                  16'(s_cmd), 16'(s_run), s_wr_data, 16'(grant), 16'(busy)};
        names = '{"m0_rd_data", "m1_rd_data", "m0_done", "m1_done", "s_addr",
                  "s_cmd", "s_run", "s_wr_data", "grant", "busy"};
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (vals[i] !== 16'h0000) begin
                errors++;
                $display("FAIL %s_%s got %h want 0000", tag, names[i], vals[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        smem[16'h0000] = 16'h1104;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int n = 0;
        expect_issue(1'b0, CMD_RD_W, 16'h0000, 16'h0000);
        raise(1'b0, CMD_RD_W, 16'h0000, 16'h0000, 16'h1104);
        while (n < 10) begin
            @(posedge clk);
            #2;
            n++;
            if (m0_done === m0_run) break;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL read_latency got %0d edges want 3", n);
        end
        checks++;
        if (m0_done !== 1'b1 || m0_rd_data !== 16'h1104 || m1_done !== 1'b0) begin
            errors++;
            $display("FAIL single_read got m0_done=%0d rd=%h m1_done=%0d want 1 1104 0",
                     m0_done, m0_rd_data, m1_done);
        end
        wait_quiet(20);
    endtask

    task automatic test_write_read();
        int c1 = done_cnt1;
        expect_issue(1'b1, CMD_WR_W, 16'h2000, 16'hBEEF);
        raise(1'b1, CMD_WR_W, 16'h2000, 16'hBEEF, 16'hBEEF);
        wait_quiet(20);
        expect_issue(1'b1, CMD_RD_W, 16'h2000, 16'h0000);
        raise(1'b1, CMD_RD_W, 16'h2000, 16'h0000, 16'hBEEF);
        wait_quiet(20);
        checks++;
        if (done_cnt1 - c1 !== 2 || m1_done !== 1'b0 || m1_rd_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_read got toggles=%0d m1_done=%0d rd=%h want 2 0 beef",
                     done_cnt1 - c1, m1_done, m1_rd_data);
        end
    endtask

    task automatic test_simultaneous();
        bit w;
        // First pair
        w = tie_winner();
        expect_issue(w,  CMD_RD_W, w ? 16'h0020 : 16'h0010, 16'h0000);
        expect_issue(~w, CMD_RD_W, w ? 16'h0010 : 16'h0020, 16'h0000);
        raise(1'b0, CMD_RD_W, 16'h0010, 16'h0000, 16'h0010 ^ 16'h5A5A);
        raise(1'b1, CMD_RD_W, 16'h0020, 16'h0000, 16'h0020 ^ 16'h5A5A);
        wait_quiet(30);
        // Lone m0 request, then a second pair
        expect_issue(1'b0, CMD_RD_W, 16'h0030, 16'h0000);
        raise(1'b0, CMD_RD_W, 16'h0030, 16'h0000, 16'h0030 ^ 16'h5A5A);
        wait_quiet(20);
        w = tie_winner();
        expect_issue(w,  CMD_RD_W, w ? 16'h0060 : 16'h0050, 16'h0000);
        expect_issue(~w, CMD_RD_W, w ? 16'h0050 : 16'h0060, 16'h0000);
        raise(1'b0, CMD_RD_W, 16'h0050, 16'h0000, 16'h0050 ^ 16'h5A5A);
        raise(1'b1, CMD_RD_W, 16'h0060, 16'h0000, 16'h0060 ^ 16'h5A5A);
        wait_quiet(30);
    endtask

    task automatic test_starvation();
        int r0 = 8, r1 = 4, k0 = 0, k1 = 0;
        bit w;
        while (r0 > 0 || r1 > 0) begin
            if (r0 > 0 && r1 > 0) w = tie_winner();
            else                  w = (r0 > 0) ? 1'b0 : 1'b1;
            if (w == 1'b0) begin
                expect_issue(1'b0, CMD_RD_W, 16'h0100 + 16'(k0), 16'h0000);
                k0++; r0--;
            end else begin
                expect_issue(1'b1, CMD_RD_W, 16'h0200 + 16'(k1), 16'h0000);
                k1++; r1--;
            end
        end
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    int t = 0;
                    logic [15:0] a;
                    while (1) begin
                        @(negedge clk);
                        if (m0_done === m0_run) break;
                        t++;
                        if (t > 200) begin
                            checks++; errors++;
                            $display("FAIL starve_m0_wait got pending want done within 200 cycles");
                            break;
                        end
                    end
                    a = 16'h0100 + 16'(k);
                    raise(1'b0, CMD_RD_W, a, 16'h0000, a ^ 16'h5A5A);
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    int t = 0;
                    logic [15:0] a;
                    while (1) begin
                        @(negedge clk);
                        if (m1_done === m1_run) break;
                        t++;
                        if (t > 200) begin
                            checks++; errors++;
                            $display("FAIL starve_m1_wait got pending want done within 200 cycles");
                            break;
                        end
                    end
                    a = 16'h0200 + 16'(k);
                    raise(1'b1, CMD_RD_W, a, 16'h0000, a ^ 16'h5A5A);
                end
            end
        join
        wait_quiet(200);
    endtask

    task automatic test_slow_slave();
        int cyc = 0, i0 = issue_cnt;
        slave_delay = 5;
        expect_issue(1'b0, CMD_WR_W, 16'h0300, 16'h1234);
        raise(1'b0, CMD_WR_W, 16'h0300, 16'h1234, 16'h1234);
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (m0_done === m0_run) break;
            checks++;
            if (busy !== 1'b1 || s_addr !== 16'h0300 || s_cmd !== CMD_WR_W || s_wr_data !== 16'h1234) begin
                errors++;
                $display("FAIL slow_hold cyc=%0d got busy=%0d addr=%h cmd=%0d wd=%h want 1 0300 1 1234",
                         cyc, busy, s_addr, s_cmd, s_wr_data);
            end
            m0_addr    = 16'hA000 + 16'(cyc);
            m0_cmd     = CMD_RD_W;
            m0_wr_data = 16'h5555 + 16'(cyc);
        end
        checks++;
        if (cyc !== 7 || issue_cnt - i0 !== 1) begin
            errors++;
            $display("FAIL slow_latency got cycles=%0d issues=%0d want 7 1", cyc, issue_cnt - i0);
        end
        wait_quiet(20);
        slave_delay = 1;
    endtask

    task automatic test_reset_abort();
        int t = 0, c1;
        slave_delay = 5;
        expect_issue(1'b1, CMD_RD_W, 16'h0400, 16'h0000);
        raise(1'b1, CMD_RD_W, 16'h0400, 16'h0000, 16'h0400 ^ 16'h5A5A);
        while (!(busy === 1'b1 && grant === 1'b1)) begin
            @(negedge clk);
            t++;
            if (t > 10) begin
                checks++; errors++;
                $display("FAIL abort_grant got busy=%0d grant=%0d want 1 1", busy, grant);
                break;
            end
        end
        #2;
        reset  = 1'b1;
        m0_run = 1'b0;
        m1_run = 1'b0;
        #1;
        check_all_zero("abort");
        mq1.delete();
        tb_last = 1'b1;
        c1 = done_cnt1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m1_done !== 1'b0 || s_run !== 1'b0 || done_cnt1 !== c1 || iq.size() !== 0) begin
            errors++;
            $display("FAIL abort_idle got busy=%0d m1_done=%0d s_run=%0d toggles=%0d iq=%0d want 0 0 0 0 0",
                     busy, m1_done, s_run, done_cnt1 - c1, iq.size());
        end
        slave_delay = 1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_simultaneous();
        test_starvation();
        test_slow_slave();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
